entropy_uart_streamer: RTL and testbench

- Sits between the randomized LFSR word source and the UART byte transmitter, replacing the fixed "send lfsr[7:0] on every word_clk" hookup.
- Buffers WORD_WIDTH-bit random words in a FIFO and serialises each word into WORD_WIDTH/8 UART bytes.
- Decodes UART command bytes to select the streaming mode: stopped, continuous, or burst of N words.
- Counts words dropped on FIFO overflow, so the host can detect entropy loss.

---
 rtl/entropy_stream_pkg.sv | 27 ++
 rtl/sync_word_fifo.sv | 60 ++++++
 rtl/entropy_uart_streamer.sv | 175 +++++++++++++++++
 tb/tb_entropy_uart_streamer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_stream_pkg.sv
// Shared encodings for the entropy UART streamer: host command bytes,
// streaming modes, command-decoder and transmit FSM states.
package entropy_stream_pkg;

  localparam logic [7:0] CMD_GO    = 8'h67;  // 'g'
  localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_CLEAR = 8'h63;  // 'c'
  localparam logic [7:0] CMD_BURST = 8'h62;  // 'b'

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    CONT    = 2'd1,
    BURST   = 2'd2
  } mode_e;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_LEN  = 1'b1
  } cmd_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with show-ahead read data, synchronous flush and a
// registered occupancy count.
module sync_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left without reset; the pointers
  // and level define which entries are valid, so clearing data buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/entropy_uart_streamer.sv
// Buffers random words, serialises them into UART bytes and decodes host
// commands that start, stop, clear or run a counted burst of the stream.
module entropy_uart_streamer
  import entropy_stream_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LSB_FIRST  = 1,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          word_valid,
  input  logic [WORD_WIDTH-1:0]         word_data,
  input  logic                          rx_received,
  input  logic [7:0]                    rx_byte,
  input  logic                          tx_free,
  output logic                          tx_transmit,
  output logic [7:0]                    tx_byte,
  output logic                          streaming,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [OVF_WIDTH-1:0]          overflow_count
);
  localparam int NB    = WORD_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  mode_e                 mode_q, mode_d;
  cmd_state_e            cmd_q, cmd_d;
  tx_state_e             tx_state_q, tx_state_d;
  logic [7:0]            burst_q, burst_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_rdata;
  logic                  clear_cmd;
  logic [IDX_W-1:0]      byte_sel;
  logic [7:0]            cur_byte;

  // A 'c' only counts as a command outside the burst-length byte.
  assign clear_cmd = rx_received && (cmd_q == CMD_IDLE) && (rx_byte == CMD_CLEAR);
  assign fifo_push = word_valid && (mode_q != STOPPED) && !clear_cmd;

  sync_word_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (word_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .flush_i (clear_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign byte_sel = (LSB_FIRST != 0) ? byte_idx_q : (LAST_IDX - byte_idx_q);

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (byte_sel == IDX_W'(i)) cur_byte = word_q[i*8 +: 8];
    end
  end

  always_comb begin
    // NOTE: every next-state value starts from its register so that no path
    // through the branches below leaves a signal unassigned and infers a latch.
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    tx_state_d  = tx_state_q;
    burst_d     = burst_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    tx_byte_d   = tx_byte_q;
    ovf_d       = ovf_q;
    fifo_pop    = 1'b0;
    tx_transmit = 1'b0;

    unique case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty && (mode_q != STOPPED)) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_rdata;
          byte_idx_d = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_free) begin
          tx_transmit = 1'b1;
          tx_byte_d   = cur_byte;
          tx_state_d  = TX_GAP;
        end
      end
      TX_GAP: begin
        if (byte_idx_q == LAST_IDX) begin
          tx_state_d = TX_IDLE;
          if (mode_q == BURST) begin
            burst_d = burst_q - 8'd1;
            if (burst_q == 8'd1) mode_d = STOPPED;
          end
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
          tx_state_d = TX_SEND;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (word_valid && (mode_q != STOPPED) && fifo_full && !clear_cmd &&
        (ovf_q != {OVF_WIDTH{1'b1}})) begin
      ovf_d = ovf_q + 1'b1;
    end
    if (clear_cmd) ovf_d = '0;

    // Host commands take priority over the burst countdown in the same cycle.
    if (rx_received) begin
      case (cmd_q)
        CMD_IDLE: begin
          case (rx_byte)
            CMD_GO:    mode_d = CONT;
            CMD_STOP:  mode_d = STOPPED;
            CMD_BURST: cmd_d  = CMD_LEN;
            default:   ;
          endcase
        end
        CMD_LEN: begin
          cmd_d = CMD_IDLE;
          if (rx_byte != 8'd0) begin
            burst_d = rx_byte;
            mode_d  = BURST;
          end
        end
        default: cmd_d = CMD_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= STOPPED;
      cmd_q      <= CMD_IDLE;
      tx_state_q <= TX_IDLE;
      burst_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      tx_byte_q  <= '0;
      ovf_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      cmd_q      <= cmd_d;
      tx_state_q <= tx_state_d;
      burst_q    <= burst_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_byte_q  <= tx_byte_d;
      ovf_q      <= ovf_d;
    end
  end

  // The byte is presented during its transmit cycle and held afterwards.
  assign tx_byte        = tx_transmit ? cur_byte : tx_byte_q;
  assign streaming      = (mode_q != STOPPED);
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_entropy_uart_streamer.sv
// Self-checking bench: directed scenarios plus a randomized stream, with the
// expected UART byte sequence built from a word-queue model of the stream.
module tb_entropy_uart_streamer;
  localparam int W  = 16;
  localparam int NB = W / 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         word_valid = 1'b0;
  logic [W-1:0] word_data = '0;
  logic         rx_received = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         tx_free = 1'b0;

  logic         tx_transmit, tx_transmit_m;
  logic [7:0]   tx_byte, tx_byte_m;
  logic         streaming, streaming_m;
  logic [3:0]   fifo_level, fifo_level_m;
  logic [15:0]  ovf;
  logic [1:0]   ovf_m;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_l[$], got_m[$], exp_l[$], exp_m[$];
  logic       prev_tx = 1'b0;

  always #5 clk = ~clk;

  entropy_uart_streamer #(
    .WORD_WIDTH(W), .FIFO_DEPTH(8), .LSB_FIRST(1), .OVF_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_data(word_data),
    .rx_received(rx_received), .rx_byte(rx_byte), .tx_free(tx_free),
    .tx_transmit(tx_transmit), .tx_byte(tx_byte), .streaming(streaming),
    .fifo_level(fifo_level), .overflow_count(ovf)
  );

  // MSB-first twin with a narrow counter to exercise saturation.
  entropy_uart_streamer #(
    .WORD_WIDTH(W), .FIFO_DEPTH(8), .LSB_FIRST(0), .OVF_WIDTH(2)
  ) dut_msb (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_data(word_data),
    .rx_received(rx_received), .rx_byte(rx_byte), .tx_free(tx_free),
    .tx_transmit(tx_transmit_m), .tx_byte(tx_byte_m), .streaming(streaming_m),
    .fifo_level(fifo_level_m), .overflow_count(ovf_m)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_transmit) begin
        got_l.push_back(tx_byte);
        check("tx_while_busy", 64'(tx_free), 64'd1);
        check("tx_back_to_back", 64'(prev_tx), 64'd0);
      end
      if (tx_transmit_m) got_m.push_back(tx_byte_m);
      prev_tx <= tx_transmit;
    end else begin
      prev_tx <= 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_received = 1'b1;
    rx_byte     = b;
    tick();
    rx_received = 1'b0;
  endtask

  task automatic strobe(input logic [W-1:0] w);
    word_valid = 1'b1;
    word_data  = w;
    tick();
    word_valid = 1'b0;
  endtask

  // Model: a word that is sent appears as NB bytes in the configured order.
  task automatic expect_word(input logic [W-1:0] w);
    for (int i = 0; i < NB; i++) begin
      exp_l.push_back(8'(w >> (8 * i)));
      exp_m.push_back(8'(w >> (8 * (NB - 1 - i))));
    end
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_count"}, 64'(got_l.size()), 64'(exp_l.size()));
    check({tag, "_count_msb"}, 64'(got_m.size()), 64'(exp_m.size()));
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++)
      check({tag, "_byte"}, 64'(got_l[i]), 64'(exp_l[i]));
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
      check({tag, "_byte_msb"}, 64'(got_m[i]), 64'(exp_m[i]));
    got_l.delete(); got_m.delete(); exp_l.delete(); exp_m.delete();
  endtask

  initial begin
    logic [W-1:0] wa;
    logic [W-1:0] bw[5];
    int           gap;

    // Reset values
    tick(3);
    check("rst_tx_transmit", 64'(tx_transmit), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_streaming", 64'(streaming), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Words are discarded while stopped
    tx_free = 1'b1;
    strobe(16'h1111);
    tick(4);
    check("stopped_level", 64'(fifo_level), 64'd0);
    check("stopped_no_tx", 64'(got_l.size()), 64'd0);

    // First-word latency and byte order
    send_cmd(8'h67);
    check("go_streaming", 64'(streaming), 64'd1);
    word_valid = 1'b1;
    word_data  = 16'hA55A;
    @(negedge clk);
    check("lat_t0_idle", 64'(tx_transmit), 64'd0);
    tick();
    word_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_idle", 64'(tx_transmit), 64'd0);
    check("lat_t1_level", 64'(fifo_level), 64'd1);
    tick();
    @(negedge clk);
    check("lat_t2_tx", 64'(tx_transmit), 64'd1);
    check("lat_t2_byte", 64'(tx_byte), 64'h5A);
    check("lat_t2_byte_msb", 64'(tx_byte_m), 64'hA5);
    tick();
    @(negedge clk);
    check("lat_t3_gap", 64'(tx_transmit), 64'd0);
    tick();
    @(negedge clk);
    check("lat_t4_tx", 64'(tx_transmit), 64'd1);
    check("lat_t4_byte", 64'(tx_byte), 64'hA5);
    tick();
    @(negedge clk);
    check("lat_t5_hold", 64'(tx_byte), 64'hA5);
    tick(4);
    strobe(16'h1234);
    tick(10);
    expect_word(16'hA55A);
    expect_word(16'h1234);
    compare_streams("order");

    // Overflow with the serialiser already holding a word, then clear
    tx_free = 1'b0;
    wa = W'($urandom);
    strobe(wa);
    tick(3);
    for (int i = 0; i < 10; i++) strobe(W'($urandom));
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_count", 64'(ovf), 64'd2);
    strobe(W'($urandom));
    strobe(W'($urandom));
    check("ovf_count_4", 64'(ovf), 64'd4);
    check("ovf_saturate", 64'(ovf_m), 64'd3);
    rx_received = 1'b1;
    rx_byte     = 8'h63;
    word_valid  = 1'b1;
    word_data   = W'($urandom);
    tick();
    rx_received = 1'b0;
    word_valid  = 1'b0;
    check("clear_level", 64'(fifo_level), 64'd0);
    check("clear_ovf", 64'(ovf), 64'd0);
    check("clear_ovf_msb", 64'(ovf_m), 64'd0);
    check("clear_keeps_mode", 64'(streaming), 64'd1);
    tx_free = 1'b1;
    tick(10);
    expect_word(wa);
    compare_streams("held_word");

    // Burst of 3 with 5 words queued
    send_cmd(8'h73);
    send_cmd(8'h62);
    send_cmd(8'h00);
    check("burst_zero", 64'(streaming), 64'd0);
    tx_free = 1'b0;
    send_cmd(8'h62);
    send_cmd(8'h03);
    check("burst_streaming", 64'(streaming), 64'd1);
    for (int i = 0; i < 5; i++) begin
      bw[i] = W'($urandom);
      strobe(bw[i]);
    end
    check("burst_queued", 64'(fifo_level), 64'd4);
    tx_free = 1'b1;
    tick(60);
    for (int i = 0; i < 3; i++) expect_word(bw[i]);
    compare_streams("burst");
    check("burst_done", 64'(streaming), 64'd0);
    check("burst_left", 64'(fifo_level), 64'd2);

    // Stop between the two bytes of a word
    tx_free = 1'b0;
    send_cmd(8'h67);
    tick(3);
    tx_free = 1'b1;
    tick();
    tx_free = 1'b0;
    send_cmd(8'h73);
    check("stop_streaming", 64'(streaming), 64'd0);
    tx_free = 1'b1;
    tick(20);
    expect_word(bw[3]);
    compare_streams("stop_mid");
    check("stop_level", 64'(fifo_level), 64'd1);
    send_cmd(8'h67);
    tick(20);
    expect_word(bw[4]);
    compare_streams("resume");
    check("resume_level", 64'(fifo_level), 64'd0);

    // Reset while a byte is being offered
    tx_free = 1'b0;
    strobe(16'hBEEF);
    tick(3);
    tx_free = 1'b1;
    #1;
    check("pre_reset_tx", 64'(tx_transmit), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("in_reset_tx", 64'(tx_transmit), 64'd0);
    check("in_reset_byte", 64'(tx_byte), 64'd0);
    check("in_reset_streaming", 64'(streaming), 64'd0);
    check("in_reset_level", 64'(fifo_level), 64'd0);
    check("in_reset_ovf", 64'(ovf), 64'd0);
    got_l.delete(); got_m.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(W'($urandom));
      tick();
    end
    tick(20);
    compare_streams("post_reset");
    check("post_reset_streaming", 64'(streaming), 64'd0);
    check("post_reset_level", 64'(fifo_level), 64'd0);

    // Randomized continuous stream with a flaky transmitter
    send_cmd(8'h67);
    for (int n = 0; n < 40; n++) begin
      wa = W'($urandom);
      tx_free = ($urandom_range(0, 3) != 0);
      strobe(wa);
      expect_word(wa);
      gap = $urandom_range(10, 16);
      for (int c = 0; c < gap; c++) begin
        tx_free = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    tx_free = 1'b1;
    tick(40);
    compare_streams("random");
    check("random_ovf", 64'(ovf), 64'd0);
    check("random_level", 64'(fifo_level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
